// File: rtl/ibex_register_file_remap.sv
// Register file with architectural-to-physical renaming: writes land in a freshly scrubbed
// spare register while the superseded one is zeroed in the background and recycled.
module ibex_register_file_remap #(
  parameter bit                   RV32E       = 1'b0,
  parameter int                   DataWidth   = 32,
  parameter int                   NumSpare    = 2,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   WrenCheck   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  output logic                 busy_o,
  output logic                 inplace_o,
  output logic                 err_o
);

  localparam int NumArch = RV32E ? 16 : 32;
  localparam int NumPhys = NumArch + NumSpare;
  localparam int IdxW    = $clog2(NumPhys);
  localparam int AddrW   = $clog2(NumArch);
  localparam int CntW    = $clog2(NumSpare + 1);

  typedef enum logic {SWEEP, RUN} state_e;
  typedef logic [IdxW-1:0] idx_t;

  state_e               state_q, state_d;
  idx_t                 sweep_q, sweep_d;
  idx_t                 map_q [NumArch];
  idx_t                 map_d [NumArch];
  idx_t                 free_q [NumSpare];
  idx_t                 free_d [NumSpare];
  idx_t                 dirty_q [NumSpare];
  idx_t                 dirty_d [NumSpare];
  logic [CntW-1:0]      free_cnt_q, free_cnt_d;
  logic [CntW-1:0]      dirty_cnt_q, dirty_cnt_d;
  logic                 inplace_q, inplace_d;
  logic [DataWidth-1:0] mem_q [NumPhys];
  logic [DataWidth-1:0] mem_d [NumPhys];

  logic [AddrW-1:0] ra_idx, rb_idx, wa_idx;
  logic             waddr_in_range, wr_eff;

  assign ra_idx = raddr_a_i[AddrW-1:0];
  assign rb_idx = raddr_b_i[AddrW-1:0];
  assign wa_idx = waddr_a_i[AddrW-1:0];

  assign busy_o         = (state_q == SWEEP);
  assign inplace_o      = inplace_q;
  assign waddr_in_range = (32'(waddr_a_i) < NumArch);
  assign wr_eff         = we_a_i && (waddr_a_i != '0) && waddr_in_range && !busy_o;
  assign err_o          = WrenCheck ? (we_a_i && (busy_o || !waddr_in_range)) : 1'b0;

  // r0, out-of-range addresses and the whole sweep read as the cleared value.
  assign rdata_a_o = ((raddr_a_i == '0) || busy_o || (32'(raddr_a_i) >= NumArch)) ?
                     WordZeroVal : mem_q[map_q[ra_idx]];
  assign rdata_b_o = ((raddr_b_i == '0) || busy_o || (32'(raddr_b_i) >= NumArch)) ?
                     WordZeroVal : mem_q[map_q[rb_idx]];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    logic scrub;
    idx_t scrub_idx;
    idx_t alloc_idx;
    state_d     = state_q;
    sweep_d     = sweep_q;
    map_d       = map_q;
    free_d      = free_q;
    free_cnt_d  = free_cnt_q;
    dirty_d     = dirty_q;
    dirty_cnt_d = dirty_cnt_q;
    inplace_d   = 1'b0;
    mem_d       = mem_q;
    scrub       = 1'b0;
    scrub_idx   = '0;
    alloc_idx   = '0;

    if (clear_i) begin
      state_d = SWEEP;
      sweep_d = '0;
      for (int k = 0; k < NumArch; k++) map_d[k] = idx_t'(k);
      for (int k = 0; k < NumSpare; k++) free_d[k] = idx_t'(NumArch + k);
      free_cnt_d  = CntW'(NumSpare);
      dirty_cnt_d = '0;
    end else if (state_q == SWEEP) begin
      mem_d[sweep_q] = WordZeroVal;
      sweep_d        = sweep_q + 1'b1;
      if (sweep_q == idx_t'(NumPhys - 1)) begin
        state_d = RUN;
        sweep_d = '0;
      end
    end else begin
      // Scrub pops the dirty head before the write pushes, so a fresh dirty entry waits a cycle.
      if (dirty_cnt_q != '0) begin
        scrub            = 1'b1;
        scrub_idx        = dirty_q[0];
        mem_d[scrub_idx] = WordZeroVal;
        for (int k = 0; k < NumSpare - 1; k++) dirty_d[k] = dirty_q[k + 1];
        dirty_cnt_d = dirty_cnt_q - 1'b1;
      end
      if (wr_eff) begin
        if (free_cnt_q != '0) begin
          alloc_idx        = free_q[0];
          mem_d[alloc_idx] = wdata_a_i;
          for (int k = 0; k < NumSpare - 1; k++) free_d[k] = free_q[k + 1];
          free_cnt_d = free_cnt_q - 1'b1;
          for (int k = 0; k < NumSpare; k++) begin
            if (dirty_cnt_d == CntW'(k)) dirty_d[k] = map_q[wa_idx];
          end
          dirty_cnt_d    = dirty_cnt_d + 1'b1;
          map_d[wa_idx]  = alloc_idx;
        end else begin
          mem_d[map_q[wa_idx]] = wdata_a_i;
          inplace_d            = 1'b1;
        end
      end
      if (scrub) begin
        for (int k = 0; k < NumSpare; k++) begin
          if (free_cnt_d == CntW'(k)) free_d[k] = scrub_idx;
        end
        free_cnt_d = free_cnt_d + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SWEEP;
      sweep_q <= '0;
      for (int k = 0; k < NumArch; k++) map_q[k] <= idx_t'(k);
      for (int k = 0; k < NumSpare; k++) begin
        free_q[k]  <= idx_t'(NumArch + k);
        dirty_q[k] <= '0;
      end
      free_cnt_q  <= CntW'(NumSpare);
      dirty_cnt_q <= '0;
      inplace_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      map_q       <= map_d;
      free_q      <= free_d;
      dirty_q     <= dirty_d;
      free_cnt_q  <= free_cnt_d;
      dirty_cnt_q <= dirty_cnt_d;
      inplace_q   <= inplace_d;
    end
  end

  // NOTE: the storage array has no reset; the post-reset sweep clears it and reads are
  // masked until the sweep completes.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ibex_register_file_remap.sv
// Bench for ibex_register_file_remap: two instances (NumSpare=2 with error reporting,
// NumSpare=1 without) share stimulus and are compared with an architectural-value model.
module tb_ibex_register_file_remap;

  localparam int A = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [4:0]  raddr_a_i, raddr_b_i, waddr_a_i;
  logic [31:0] wdata_a_i;
  logic        we_a_i;

  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        busy0, inplace0, err0, busy1, inplace1, err1;

  int checks = 0;
  int errors = 0;

  ibex_register_file_remap #(.WrenCheck(1'b1)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a0),
    .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b0),
    .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
    .busy_o(busy0), .inplace_o(inplace0), .err_o(err0)
  );

  ibex_register_file_remap #(.NumSpare(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a1),
    .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b1),
    .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
    .busy_o(busy1), .inplace_o(inplace1), .err_o(err1)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: architectural values plus occupancy of the spare pool per instance.
  int          ns [2]      = '{2, 1};
  int          err_en [2]  = '{1, 0};
  logic [31:0] arch [2][A];
  bit          m_busy [2];
  int          m_left [2];
  int          m_free [2];
  int          m_dirty [2];
  bit          m_inplace [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_busy[i]    = 1'b1;
    m_left[i]    = A + ns[i];
    m_free[i]    = ns[i];
    m_dirty[i]   = 0;
    m_inplace[i] = 1'b0;
    for (int r = 0; r < A; r++) arch[i][r] = '0;
  endtask

  task automatic model_edge(input int i, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic clr);
    bit do_scrub;
    if (clr) begin
      model_reset(i);
      return;
    end
    m_inplace[i] = 1'b0;
    if (m_busy[i]) begin
      m_left[i]--;
      if (m_left[i] == 0) m_busy[i] = 1'b0;
      return;
    end
    do_scrub = (m_dirty[i] > 0);
    if (we && wa != 0) begin
      if (m_free[i] > 0) begin
        m_free[i]--;
        m_dirty[i]++;
      end else begin
        m_inplace[i] = 1'b1;
      end
      arch[i][wa] = wd;
    end
    if (do_scrub) begin
      m_dirty[i]--;
      m_free[i]++;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ea, eb;
    for (int i = 0; i < 2; i++) begin
      ea = m_busy[i] ? 32'h0 : arch[i][raddr_a_i];
      eb = m_busy[i] ? 32'h0 : arch[i][raddr_b_i];
      check($sformatf("rdata_a%0d[x%0d]", i, raddr_a_i), (i == 0) ? rdata_a0 : rdata_a1, ea);
      check($sformatf("rdata_b%0d[x%0d]", i, raddr_b_i), (i == 0) ? rdata_b0 : rdata_b1, eb);
      check($sformatf("busy%0d", i), {31'b0, (i == 0) ? busy0 : busy1}, {31'b0, m_busy[i]});
      check($sformatf("inplace%0d", i), {31'b0, (i == 0) ? inplace0 : inplace1},
            {31'b0, m_inplace[i]});
      check($sformatf("err%0d", i), {31'b0, (i == 0) ? err0 : err1},
            {31'b0, (err_en[i] != 0) && we_a_i && m_busy[i]});
    end
  endtask

  // Called just after a rising edge: drive, check combinational view, then advance one cycle.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic clr);
    we_a_i    = we;
    waddr_a_i = wa;
    wdata_a_i = wd;
    raddr_a_i = ra;
    raddr_b_i = rb;
    clear_i   = clr;
    #1;
    check_outputs();
    @(posedge clk_i);
    for (int i = 0; i < 2; i++) model_edge(i, we, wa, wd, clr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'h0, 5'(k), 5'(k + 7), 1'b0);
  endtask

  task automatic count_sweep(input string tag);
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      step(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b0);
    end
    check({tag, "_busy_cycles0"}, n0, 34);
    check({tag, "_busy_cycles1"}, n1, 33);
  endtask

  task automatic read_all_zero();
    for (int r = 0; r < A; r++) step(1'b0, 5'd0, 32'h0, 5'(r), 5'(A - 1 - r), 1'b0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    clear_i   = 1'b0;
    we_a_i    = 1'b0;
    waddr_a_i = '0;
    wdata_a_i = '0;
    raddr_a_i = 5'd5;
    raddr_b_i = 5'd9;
    for (int i = 0; i < 2; i++) model_reset(i);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy0", {31'b0, busy0}, 32'd1);
    check("reset_busy1", {31'b0, busy1}, 32'd1);
    check("reset_inplace0", {31'b0, inplace0}, 32'd0);
    check("reset_rdata_a0", rdata_a0, 32'h0);
    rst_ni = 1'b1;

    count_sweep("post_reset");
    read_all_zero();

    // Single write, same-cycle read sees old value, next cycle sees new.
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0);
    idle(3);

    // Back-to-back writes: the NumSpare=1 instance runs out of spares on the second.
    step(1'b1, 5'd3, 32'h3333_0003, 5'd3, 5'd4, 1'b0);
    step(1'b1, 5'd4, 32'h4444_0004, 5'd3, 5'd4, 1'b0);
    check("x4_inplace1", {31'b0, inplace1}, 32'd1);
    check("x4_inplace0", {31'b0, inplace0}, 32'd0);
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0);
    step(1'b1, 5'd6, 32'h6666_0006, 5'd3, 5'd4, 1'b0);
    check("x6_inplace1", {31'b0, inplace1}, 32'd0);
    step(1'b0, 5'd0, 32'h0, 5'd6, 5'd5, 1'b0);

    // x0 is never written.
    step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
    check("x0_reads_zero", rdata_a0, 32'h0);

    // Clear, write during busy is dropped and flagged, clear again mid-sweep.
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b1);
    step(1'b1, 5'd7, 32'h7777_7777, 5'd7, 5'd5, 1'b0);
    check("busy_write_err0", {31'b0, err0}, 32'd1);
    check("busy_write_err1", {31'b0, err1}, 32'd0);
    idle(10);
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 1'b1);
    count_sweep("reclear");
    read_all_zero();

    // Random write every cycle.
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 1'b0);
    end
    for (int r = 0; r < A; r++) step(1'b0, 5'd0, 32'h0, 5'(r), 5'(r), 1'b0);

    // Asynchronous reset in the middle of activity.
    step(1'b1, 5'd9, 32'h9999_0009, 5'd9, 5'd5, 1'b0);
    raddr_a_i = 5'd9;
    rst_ni    = 1'b0;
    #1;
    check("midrun_reset_busy0", {31'b0, busy0}, 32'd1);
    check("midrun_reset_busy1", {31'b0, busy1}, 32'd1);
    check("midrun_reset_rdata0", rdata_a0, 32'h0);
    for (int i = 0; i < 2; i++) model_reset(i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    count_sweep("midrun_reset");
    read_all_zero();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
